// File: rtl/dl_pkg.sv
// Shared types and constants for the ROM download controller.
// States, byte-enable encodings and the default reset stretch length.
package dl_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      BUSY  = 2'd2
   } dl_state_t;

   localparam logic [1:0]  DS_LO = 2'b01;
   localparam logic [1:0]  DS_HI = 2'b10;
   localparam logic [1:0]  DS_W  = 2'b11;

   localparam logic [15:0] RESET_CYCLES_DEF = 16'hFFFF;

endpackage

// File: rtl/rst_stretch.sv
// Reload/decrement counter that stretches the game core reset.
// rst_out stays high until the counter has run down to zero.
module rst_stretch
   import dl_pkg::*;
#(
   parameter logic [15:0] N = RESET_CYCLES_DEF
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic hold,
   output logic rst_out
);

   logic [15:0] count_q;
   logic        rst_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset || hold) begin
         count_q <= N;
         rst_q   <= 1'b1;
      end else begin
         // Saturating countdown: zero is sticky until the next reload.
         if (count_q != 16'd0) count_q <= count_q - 16'd1;
         rst_q <= (count_q != 16'd0);
      end
   end

   assign rst_out = rst_q;

endmodule

// File: rtl/rom_dl_ctrl.sv
// Packs data_io download bytes into 16-bit SDRAM writes over a toggle req/ack port,
// and generates rom_loaded plus the stretched core reset.
module rom_dl_ctrl
   import dl_pkg::*;
#(
   parameter logic [7:0]  ROM_INDEX    = 8'd0,
   parameter logic [15:0] RESET_CYCLES = RESET_CYCLES_DEF,
   parameter int          AW           = 23
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          reset_req,
   input  logic          ioctl_downl,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   output logic          port_req,
   input  logic          port_ack,
   output logic [AW-1:0] port_a,
   output logic [1:0]    port_ds,
   output logic          port_we,
   output logic [15:0]   port_d,
   output logic          rom_loaded,
   output logic          core_reset,
   output logic          overflow
);

   dl_state_t     state_q, state_d;
   logic          wr_q, dl_seen_q, rom_loaded_q;
   logic          req_q, overflow_q, overflow_d;
   logic [AW-1:0] a_q;
   logic [15:0]   d_q;
   logic [1:0]    ds_q;
   logic [7:0]    pend_data_q, pend_data_d;
   logic [AW-1:0] pend_addr_q, pend_addr_d;
   logic          hold_valid_q, hold_valid_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic [AW:0]   hold_addr_q, hold_addr_d;

   logic          issue;
   logic [AW-1:0] iss_a;
   logic [15:0]   iss_d;
   logic [1:0]    iss_ds;
   logic          src_valid;
   logic [7:0]    src_data;
   logic [AW:0]   src_addr;
   logic          acc, ack_match, unused_addr;

   assign acc         = ioctl_wr & ~wr_q & ioctl_downl & (ioctl_index == ROM_INDEX);
   assign ack_match   = (port_ack == req_q);
   assign unused_addr = ^ioctl_addr[24:AW+1];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      overflow_d   = overflow_q;
      pend_data_d  = pend_data_q;
      pend_addr_d  = pend_addr_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_addr_d  = hold_addr_q;
      issue        = 1'b0;
      iss_a        = pend_addr_q;
      iss_d        = {8'h00, pend_data_q};
      iss_ds       = DS_LO;
      src_valid    = 1'b0;
      src_data     = ioctl_dout;
      src_addr     = ioctl_addr[AW:0];

      case (state_q)
         EMPTY: src_valid = acc;
         HALF: begin
            if (acc) begin
               issue   = 1'b1;
               state_d = BUSY;
               if (ioctl_addr[0] && (ioctl_addr[AW:1] == pend_addr_q)) begin
                  iss_d  = {ioctl_dout, pend_data_q};
                  iss_ds = DS_W;
               end else begin
                  hold_valid_d = 1'b1;
                  hold_data_d  = ioctl_dout;
                  hold_addr_d  = ioctl_addr[AW:0];
               end
            end else if (!ioctl_downl) begin
               issue   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (ack_match) begin
               state_d = EMPTY;
               if (hold_valid_q) begin
                  src_valid    = 1'b1;
                  src_data     = hold_data_q;
                  src_addr     = hold_addr_q;
                  hold_valid_d = 1'b0;
                  overflow_d   = overflow_q | acc;
               end else begin
                  src_valid = acc;
               end
            end else if (acc) begin
               if (hold_valid_q) begin
                  overflow_d = 1'b1;
               end else begin
                  hold_valid_d = 1'b1;
                  hold_data_d  = ioctl_dout;
                  hold_addr_d  = ioctl_addr[AW:0];
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      // A fresh byte from the idle position: odd bytes go out alone, even bytes wait for a partner.
      if (src_valid) begin
         if (src_addr[0]) begin
            issue   = 1'b1;
            iss_a   = src_addr[AW:1];
            iss_d   = {src_data, 8'h00};
            iss_ds  = DS_HI;
            state_d = BUSY;
         end else begin
            pend_data_d = src_data;
            pend_addr_d = src_addr[AW:1];
            state_d     = HALF;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= EMPTY;
         hold_valid_q <= 1'b0;
         wr_q         <= 1'b0;
         req_q        <= port_ack;
         a_q          <= '0;
         d_q          <= '0;
         ds_q         <= '0;
         overflow_q   <= 1'b0;
         rom_loaded_q <= 1'b0;
         dl_seen_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         wr_q         <= ioctl_wr;
         overflow_q   <= overflow_d;
         dl_seen_q    <= dl_seen_q | (ioctl_downl & (ioctl_index == ROM_INDEX));
         if (dl_seen_q && !ioctl_downl && (state_q == EMPTY) && !hold_valid_q)
            rom_loaded_q <= 1'b1;
         if (issue) begin
            a_q   <= iss_a;
            d_q   <= iss_d;
            ds_q  <= iss_ds;
            req_q <= ~req_q;
         end
      end
   end

   // NOTE: byte storage needs no reset; the state and valid flags gate every use of it.
   always_ff @(posedge clk_sys) begin
      pend_data_q <= pend_data_d;
      pend_addr_q <= pend_addr_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
   end

   rst_stretch #(.N(RESET_CYCLES)) u_rst_stretch (
      .clk_sys (clk_sys),
      .reset   (reset),
      .hold    (reset_req | ~rom_loaded_q | ioctl_downl),
      .rst_out (core_reset)
   );

   assign ioctl_wait = (state_q == BUSY) | hold_valid_q;
   assign port_req   = req_q;
   assign port_a     = a_q;
   assign port_d     = d_q;
   assign port_ds    = ds_q;
   assign port_we    = ioctl_downl;
   assign rom_loaded = rom_loaded_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl: responder acks after a programmable delay,
// a monitor logs each issued write, and the main thread checks against hand-computed values.
module tb_rom_dl_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset, reset_req, ioctl_downl, ioctl_wr, port_ack;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait, port_req, port_we, rom_loaded, core_reset, overflow;
   logic [22:0] port_a;
   logic [1:0]  port_ds;
   logic [15:0] port_d;

   typedef struct packed {
      logic [22:0] a;
      logic [15:0] d;
      logic [1:0]  ds;
   } wr_t;

   wr_t  wq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ack_dly = 2;
   bit   ack_en = 1'b0;
   int   ack_cnt = 0;
   logic req_prev = 1'b0;

   always #5 clk_sys = ~clk_sys;

   rom_dl_ctrl #(
      .ROM_INDEX    (8'd0),
      .RESET_CYCLES (16'd16),
      .AW           (23)
   ) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .reset_req   (reset_req),
      .ioctl_downl (ioctl_downl),
      .ioctl_index (ioctl_index),
      .ioctl_wr    (ioctl_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .ioctl_wait  (ioctl_wait),
      .port_req    (port_req),
      .port_ack    (port_ack),
      .port_a      (port_a),
      .port_ds     (port_ds),
      .port_we     (port_we),
      .port_d      (port_d),
      .rom_loaded  (rom_loaded),
      .core_reset  (core_reset),
      .overflow    (overflow)
   );

   // Write monitor and SDRAM ack responder.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (port_req !== req_prev) wq.push_back({port_a, port_d, port_ds});
         req_prev = port_req;
         if (ack_en && (port_req !== port_ack)) begin
            ack_cnt++;
            if (ack_cnt >= ack_dly) begin
               port_ack = port_req;
               ack_cnt  = 0;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [22:0] a,
                           input logic [15:0] d, input logic [1:0] ds);
      if (wq.size() > idx) begin
         check($sformatf("%s_a", tag), 32'(wq[idx].a), 32'(a));
         check($sformatf("%s_d", tag), 32'(wq[idx].d), 32'(d));
         check($sformatf("%s_ds", tag), 32'(wq[idx].ds), 32'(ds));
      end else begin
         check($sformatf("%s_missing", tag), 32'(wq.size()), 32'(idx + 1));
      end
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_sys);
         if (!ioctl_wait && (port_req === port_ack)) done = 1'b1;
      end
      check($sformatf("%s_idle", tag), 32'(done), 32'd1);
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d, input string tag);
      strobe(a, d);
      wait_idle(tag);
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      #1 wq.delete();
   endtask

   initial begin
      int cnt;
      bit done;
      reset       = 1'b1;
      reset_req   = 1'b0;
      ioctl_downl = 1'b0;
      ioctl_index = 8'd0;
      ioctl_wr    = 1'b0;
      ioctl_addr  = '0;
      ioctl_dout  = '0;
      port_ack    = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      #1 wq.delete();
      ack_en = 1'b1;

      // Reset state
      check("rst_req", 32'(port_req), 32'(port_ack));
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_loaded", 32'(rom_loaded), 32'd0);
      check("rst_core", 32'(core_reset), 32'd1);
      check("rst_ds", 32'(port_ds), 32'd0);
      check("rst_a", 32'(port_a), 32'd0);

      // Index filter: wrong target index produces no writes and no load
      ioctl_index = 8'd1;
      ioctl_downl = 1'b1;
      send(25'd0, 8'hAA, "idx0");
      send(25'd1, 8'hBB, "idx1");
      ioctl_downl = 1'b0;
      repeat (6) @(negedge clk_sys);
      check("idx_nwr", 32'(wq.size()), 32'd0);
      check("idx_loaded", 32'(rom_loaded), 32'd0);
      ioctl_index = 8'd0;

      // Odd-length download: trailing even byte is flushed when downl drops
      ioctl_downl = 1'b1;
      send(25'd0, 8'h11, "odd0");
      send(25'd1, 8'h22, "odd1");
      send(25'd2, 8'h33, "odd2");
      check("odd_we", 32'(port_we), 32'd1);
      check("odd_loaded_pre", 32'(rom_loaded), 32'd0);
      ioctl_downl = 1'b0;
      wait_idle("odd_flush");
      @(negedge clk_sys);
      check("odd_loaded", 32'(rom_loaded), 32'd1);
      check("odd_we_off", 32'(port_we), 32'd0);
      check("odd_nwr", 32'(wq.size()), 32'd2);
      check_wr("odd_w0", 0, 23'd0, 16'h2211, 2'b11);
      check_wr("odd_w1", 1, 23'd1, 16'h0033, 2'b01);
      wq.delete();

      // Contiguous download of four bytes
      ioctl_downl = 1'b1;
      send(25'd0, 8'h11, "ct0");
      send(25'd1, 8'h22, "ct1");
      send(25'd2, 8'h33, "ct2");
      send(25'd3, 8'h44, "ct3");
      ioctl_downl = 1'b0;
      wait_idle("ct_end");
      check("ct_nwr", 32'(wq.size()), 32'd2);
      check_wr("ct_w0", 0, 23'd0, 16'h2211, 2'b11);
      check_wr("ct_w1", 1, 23'd1, 16'h4433, 2'b11);
      wq.delete();

      // Back-pressure: slow ack, one held byte, one overflow
      ack_dly = 10;
      ioctl_downl = 1'b1;
      strobe(25'd5, 8'h55);
      strobe(25'd7, 8'h77);
      check("bp_wait_hold", 32'(ioctl_wait), 32'd1);
      check("bp_ovf0", 32'(overflow), 32'd0);
      strobe(25'd9, 8'h99);
      check("bp_ovf", 32'(overflow), 32'd1);
      check("bp_wait_still", 32'(ioctl_wait), 32'd1);
      check("bp_n1", 32'(wq.size()), 32'd1);
      wait_idle("bp_end");
      check("bp_nwr", 32'(wq.size()), 32'd2);
      check_wr("bp_w0", 0, 23'd2, 16'h5500, 2'b10);
      check_wr("bp_w1", 1, 23'd3, 16'h7700, 2'b10);
      ioctl_downl = 1'b0;
      wait_idle("bp_off");
      ack_dly = 2;
      wq.delete();

      // Reset stretch: one-cycle reset_req pulse keeps core_reset high 17 cycles
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk_sys);
         if (!core_reset) done = 1'b1;
      end
      check("rs_idle_low", 32'(core_reset), 32'd0);
      @(negedge clk_sys);
      reset_req = 1'b1;
      @(negedge clk_sys);
      reset_req = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!core_reset) break;
         cnt++;
         @(negedge clk_sys);
      end
      check("rs_len", 32'(cnt), 32'd17);
      check("rs_end", 32'(core_reset), 32'd0);

      // Reset while a write is outstanding, with a byte held
      ack_en = 1'b0;
      ioctl_downl = 1'b1;
      strobe(25'd1, 8'hAB);
      strobe(25'd3, 8'hCD);
      check("mw_wait", 32'(ioctl_wait), 32'd1);
      check("mw_pending", 32'(port_req != port_ack), 32'd1);
      do_reset();
      check("mw_req", 32'(port_req), 32'(port_ack));
      check("mw_wait_rst", 32'(ioctl_wait), 32'd0);
      check("mw_loaded_rst", 32'(rom_loaded), 32'd0);
      check("mw_ovf_rst", 32'(overflow), 32'd0);
      check("mw_core_rst", 32'(core_reset), 32'd1);
      ack_en = 1'b1;
      send(25'd0, 8'hC0, "mw0");
      send(25'd1, 8'hC1, "mw1");
      ioctl_downl = 1'b0;
      wait_idle("mw_end");
      @(negedge clk_sys);
      check("mw_nwr", 32'(wq.size()), 32'd1);
      check_wr("mw_w0", 0, 23'd0, 16'hC1C0, 2'b11);
      check("mw_loaded", 32'(rom_loaded), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
